// File: rtl/rx_frame_checker.sv
// rx_frame_checker
// Serial frame receiver with popcount checksum check.
// Frames arrive LSB first as {chk, data}. Data is DATA_W bits wide and the
// checksum field is CHK_W = $clog2(DATA_W+1) bits wide. The expected checksum
// is the popcount of every data bit, bitwise inverted when INVERT=1. Each
// finished frame is presented on a valid/ready output port together with an
// OK flag. Saturating counters track good frames, bad frames and aborted
// frames.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   rx_bit     serial bit (frame bit 0 = data LSB comes first)
//   rx_valid   rx_bit valid; a bit transfers on rx_valid && rx_ready
//   rx_sof     marks the transferring bit as frame bit 0
//   rx_ready   receiver can accept a bit this cycle
//   out_data   received payload
//   out_chk    received checksum field
//   out_ok     received checksum matches the computed one
//   out_valid  output word valid
//   out_ready  consumer accepts; a word transfers on out_valid && out_ready
//   ok_cnt     frames completed with out_ok=1 (saturating)
//   err_cnt    frames completed with out_ok=0 (saturating)
//   abort_cnt  frames restarted by rx_sof mid-frame (saturating)
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for a bit qualified by rx_sof; other bits are dropped
// SHIFT | collecting frame bits; count = index of the next bit expected

module rx_frame_checker #(
    parameter int DATA_W = 7,
    parameter bit INVERT = 1'b1,
    parameter int CNT_W  = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           rx_bit,
    input  logic                           rx_valid,
    input  logic                           rx_sof,
    output logic                           rx_ready,
    output logic [DATA_W-1:0]              out_data,
    output logic [$clog2(DATA_W+1)-1:0]    out_chk,
    output logic                           out_ok,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [CNT_W-1:0]               ok_cnt,
    output logic [CNT_W-1:0]               err_cnt,
    output logic [CNT_W-1:0]               abort_cnt
);

    localparam int CHK_W   = $clog2(DATA_W + 1);
    localparam int FRAME_W = DATA_W + CHK_W;
    localparam int IDX_W   = $clog2(FRAME_W);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_W - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   count;
    logic [FRAME_W-1:0] shreg;

    logic               last_bit;
    logic               xfer;
    logic               complete;
    logic               out_take;
    logic [FRAME_W-1:0] frame_full;
    logic [CHK_W-1:0]   pop;
    logic [CHK_W-1:0]   expected;
    logic               chk_match;

    // The only bit that can be stalled is the one that would complete a
    // frame while an unaccepted word is still sitting in the output register.
    assign last_bit = (state == SHIFT) && (count == LAST_IDX);
    assign rx_ready = !(last_bit && out_valid && !out_ready);
    assign xfer     = rx_valid && rx_ready;
    assign complete = xfer && last_bit && !rx_sof;
    assign out_take = out_valid && out_ready;

    // The final bit is still on rx_bit, so the complete frame is assembled
    // here rather than waiting a cycle for it to land in shreg.
    assign frame_full = {rx_bit, shreg[FRAME_W-2:0]};

    // CHK_W is sized to hold DATA_W, so the popcount cannot overflow.
    always_comb begin
        pop = '0;
        for (int i = 0; i < DATA_W; i++) begin
            pop = pop + CHK_W'(frame_full[i]);
        end
    end

    assign expected  = INVERT ? ~pop : pop;
    assign chk_match = (frame_full[FRAME_W-1:DATA_W] == expected);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            count     <= '0;
            shreg     <= '0;
            out_data  <= '0;
            out_chk   <= '0;
            out_ok    <= 1'b0;
            out_valid <= 1'b0;
            ok_cnt    <= '0;
            err_cnt   <= '0;
            abort_cnt <= '0;
        end else begin
            // A completion on the same edge as a take overrides the clear,
            // so back-to-back words keep out_valid high.
            if (out_take) begin
                out_valid <= 1'b0;
            end

            if (complete) begin
                out_data  <= frame_full[DATA_W-1:0];
                out_chk   <= frame_full[FRAME_W-1:DATA_W];
                out_ok    <= chk_match;
                out_valid <= 1'b1;
                if (chk_match) begin
                    if (~&ok_cnt) begin
                        ok_cnt <= ok_cnt + 1'b1;
                    end
                end else begin
                    if (~&err_cnt) begin
                        err_cnt <= err_cnt + 1'b1;
                    end
                end
            end

            if (xfer) begin
                case (state)
                    IDLE: begin
                        if (rx_sof) begin
                            state <= SHIFT;
                            shreg <= FRAME_W'(rx_bit);
                            count <= IDX_W'(1);
                        end
                    end
                    SHIFT: begin
                        if (rx_sof) begin
                            // Restart: this bit becomes bit 0 of a new frame.
                            if (~&abort_cnt) begin
                                abort_cnt <= abort_cnt + 1'b1;
                            end
                            shreg <= FRAME_W'(rx_bit);
                            count <= IDX_W'(1);
                        end else if (last_bit) begin
                            state <= IDLE;
                            count <= '0;
                        end else begin
                            shreg[count] <= rx_bit;
                            count        <= count + 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        count <= '0;
                    end
                endcase
            end
        end
    end

endmodule
